// File: rtl/countdown_arbiter_if.sv
// Request/grant/status bundle between two countdown clients and the shared
// countdown_arbiter; clients drive the master side, the arbiter the slave side.
interface countdown_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (
        output req0, req1, len0, len1,
        input  gnt0, gnt1, done0, done1, busy, count
    );

    modport slave (
        input  req0, req1, len0, len1,
        output gnt0, gnt1, done0, done1, busy, count
    );
endinterface

// File: rtl/countdown_arbiter.sv
// Two-requester scheduler for one shared down counter: arbitrate, load, count to
// zero, pulse done. Define ROUND_ROBIN_EN for round-robin; default is fixed priority.
module countdown_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    countdown_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [1:0]       done_reg, done_next;
    logic             busy_reg, busy_next;
    logic [1:0]       req;
    logic             win;     // 1 selects requester 1

    assign req = {bus.req1, bus.req0};

`ifdef ROUND_ROBIN_EN
    logic last_reg, last_next;

    // On contention the requester that did not own the counter last wins.
    always_comb begin
        win = (req == 2'b11) ? ~last_reg : req[1];
    end

    always_comb begin
        last_next = last_reg;
        if (state_reg == IDLE && (|req)) begin
            last_next = win;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end
`else
    always_comb begin
        win = ~req[0];
    end
`endif

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        gnt_next   = gnt_reg;
        done_next  = 2'b00;
        unique case (state_reg)
            IDLE: begin
                count_next = '1;
                gnt_next   = 2'b00;
                if (|req) begin
                    state_next = RUN;
                    count_next = win ? bus.len1 : bus.len0;
                    gnt_next   = win ? 2'b10 : 2'b01;
                end
            end
            RUN: begin
                if (count_reg != '0) begin
                    count_next = count_reg - 1'b1;
                end else begin
                    state_next = DONE;
                    done_next  = gnt_reg;
                end
            end
            DONE: begin
                state_next = IDLE;
                count_next = '1;
                gnt_next   = 2'b00;
            end
            default: begin
                state_next = IDLE;
                count_next = '1;
                gnt_next   = 2'b00;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '1;
            gnt_reg   <= 2'b00;
            done_reg  <= 2'b00;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign bus.gnt0  = gnt_reg[0];
    assign bus.gnt1  = gnt_reg[1];
    assign bus.done0 = done_reg[0];
    assign bus.done1 = done_reg[1];
    assign bus.busy  = busy_reg;
    assign bus.count = count_reg;
endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed plus randomized bench for countdown_arbiter; each granted job is expanded
// into its full expected output trace which is then consumed one cycle at a time.
module tb_countdown_arbiter;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic             gnt0;
        logic             gnt1;
        logic             done0;
        logic             done1;
        logic             busy;
        logic [WIDTH-1:0] count;
    } obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    obs_t exp_q[$];
    logic m_last;

    countdown_arbiter_if #(.WIDTH(WIDTH)) bus ();

    countdown_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t idle_obs();
        obs_t r;
        r       = '0;
        r.count = '1;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.gnt0  = bus.gnt0;
        r.gnt1  = bus.gnt1;
        r.done0 = bus.done0;
        r.done1 = bus.done1;
        r.busy  = bus.busy;
        r.count = bus.count;
        return r;
    endfunction

    // Reference: a job of length L owned by W shows L+1 counting cycles then one done cycle.
    task automatic model_edge();
        int          w;
        int          l;
        obs_t        e;
        if (!reset) begin
            exp_q.delete();
            m_last = 1'b1;
        end else if (exp_q.size() == 0) begin
            if (bus.req0 || bus.req1) begin
`ifdef ROUND_ROBIN_EN
                if (bus.req0 && bus.req1) w = (m_last == 1'b0) ? 1 : 0;
                else                      w = bus.req0 ? 0 : 1;
`else
                w = bus.req0 ? 0 : 1;
`endif
                m_last = (w == 1);
                l = (w == 1) ? int'(bus.len1) : int'(bus.len0);
                for (int k = l; k >= 0; k--) begin
                    e       = '0;
                    e.gnt0  = (w == 0);
                    e.gnt1  = (w == 1);
                    e.busy  = 1'b1;
                    e.count = WIDTH'(k);
                    exp_q.push_back(e);
                end
                e       = '0;
                e.gnt0  = (w == 0);
                e.gnt1  = (w == 1);
                e.done0 = (w == 0);
                e.done1 = (w == 1);
                e.busy  = 1'b1;
                e.count = '0;
                exp_q.push_back(e);
            end
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check(input string tag);
        obs_t o;
        obs_t e;
        o = observe();
        e = (exp_q.size() != 0) ? exp_q[0] : idle_obs();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
        $display("cyc %0d %-12s rst=%b req=%b%b gnt=%b%b done=%b%b busy=%b count=%0d",
                 cyc, tag, reset, bus.req1, bus.req0, bus.gnt1, bus.gnt0,
                 bus.done1, bus.done0, bus.busy, bus.count);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        m_last   = 1'b1;
        reset    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.len0 = '0;
        bus.len1 = '0;
        @(negedge clk);
        check("reset");
        reset = 1'b1;
        repeat (2) cycle("idle");

        // Single job of length 3 from requester 0
        bus.req0 = 1'b1;
        bus.len0 = 4'd3;
        cycle("single");
        bus.req0 = 1'b0;
        repeat (6) cycle("single");

        // Zero-length job from requester 1
        bus.req1 = 1'b1;
        bus.len1 = 4'd0;
        cycle("zero_len");
        bus.req1 = 1'b0;
        repeat (4) cycle("zero_len");

        // Held contention
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.len0 = 4'd2;
        bus.len1 = 4'd1;
        repeat (16) cycle("contend");
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (4) cycle("contend");

        // Reset in the middle of a long job
        bus.req0 = 1'b1;
        bus.len0 = 4'd15;
        cycle("long_job");
        bus.req0 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0 && exp_q[0].count == 4'd9) begin
                hit = 1'b1;
                break;
            end
            cycle("long_job");
        end
        checks++;
        assert (hit && bus.count == 4'd9) else begin
            errors++;
            $error("FAIL reach_count9 observed=%0d expected=9", bus.count);
        end
        reset = 1'b0;
        #1;
        exp_q.delete();
        m_last = 1'b1;
        check("async_rst");
        cycle("rst_held");
        reset = 1'b1;
        repeat (4) cycle("no_resume");

        // Late len/req changes after grant
        bus.req0 = 1'b1;
        bus.len0 = 4'd5;
        cycle("late_chg");
        bus.req0 = 1'b0;
        bus.len0 = 4'(($urandom % 16));
        bus.req1 = 1'b1;
        bus.len1 = 4'd2;
        repeat (3) cycle("late_chg");
        bus.req1 = 1'b0;
        repeat (8) cycle("late_chg");

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 300; i++) begin
            bus.req0 = ($urandom % 3) == 0;
            bus.req1 = ($urandom % 3) == 0;
            bus.len0 = 4'($urandom % 16);
            bus.len1 = 4'($urandom % 16);
            if (($urandom % 60) == 0) begin
                reset = 1'b0;
                #1;
                exp_q.delete();
                m_last = 1'b1;
                check("rand_rst");
                cycle("rand_rst");
                reset = 1'b1;
            end
            cycle("rand");
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (20) cycle("drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_arbiter.md
# countdown_arbiter

Two-requester scheduler for a shared WIDTH-bit down counter. Each requester asks for a countdown job of a given length; the block arbitrates, loads the counter, decrements it once per clock to zero, and reports completion with a one-cycle done pulse. It sits between client logic needing timed delays and the single counter resource, so only one job owns the counter at a time.

## Interface
- WIDTH, default 4: counter and job-length width in bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- req0, req1  in  1 each  level request; sampled only in IDLE.
- len0, len1  in  WIDTH each  job length; sampled only on the granting edge.
- gnt0, gnt1  out  1 each  owner indication; high from load through DONE; one-hot or zero.
- done0, done1  out  1 each  one-cycle pulse in DONE state for the owner.
- busy  out  1  high in RUN and DONE.
- count  out  WIDTH  current counter value.

## Operation
- States: IDLE, RUN, DONE (registered FSM).
- IDLE: count = all ones (4'b1111 at WIDTH=4), gnt*/done* = 0, busy = 0.
  - No req: stay IDLE.
  - Any req: winner chosen per arbitration; next edge: RUN, gnt of winner = 1, count = winner's len.
- RUN: each edge with count != 0: count decrements by 1. Edge with count == 0: go DONE, count held at 0, owner's done = 1.
- DONE: lasts exactly one cycle; next edge: IDLE, gnt = 0, done = 0, count = all ones.
- Count never wraps below 0; no subtraction occurs when count == 0.
- len = 0: RUN lasts one cycle (count 0), then DONE.
- Requests seen during RUN/DONE are ignored; dropping req mid-job does not abort it; len changes after grant have no effect.
- Requester holding req through DONE is re-arbitrated in the following IDLE cycle.
- Arbitration (see Configuration) uses a last-owner pointer updated on each grant; reset sets pointer = 1 so req0 wins the first contention.
- reset low in any state: outputs and pointer return to reset values asynchronously; in-flight job discarded, no done pulse.

## Timing
- Reset values: gnt0 = gnt1 = 0, done0 = done1 = 0, busy = 0, count = all ones, state IDLE.
- Request sampled at edge E1 in IDLE -> gnt and count = len visible after E1.
- RUN occupies len+1 cycles (count len, len-1, ..., 0).
- done pulse after edge E1+len+1; IDLE after E1+len+2.
- Job-to-job minimum spacing: one IDLE cycle between DONE and the next grant.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- ROUND_ROBIN_EN defined: on simultaneous req0 and req1, the requester that was not the last owner wins; single request always wins.
- ROUND_ROBIN_EN undefined: fixed priority, req0 always beats req1; last-owner pointer unused (may be optimised out).

## Test plan
- Reset: hold reset = 0 mid-stimulus -> count = 4'b1111, all gnt/done/busy = 0; release -> stays IDLE with no req.
- Single job: req0 = 1, len0 = 3 -> gnt0 after 1 edge, count 3,2,1,0, done0 pulse one cycle after count reaches 0, then IDLE with count = 4'b1111.
- Zero length: req1 = 1, len1 = 0 -> gnt1, count 0 for one cycle, done1 next cycle, total 3 edges IDLE-to-IDLE.
- Contention held, ROUND_ROBIN_EN defined: req0 = req1 = 1, len0 = 2, len1 = 1 -> grants alternate gnt0, gnt1, gnt0; undefined -> gnt0 every job, gnt1 never.
- Reset mid-job: req0, len0 = 15, assert reset at count = 9 -> immediate reset values, no done0; after release job is not resumed.
- Late input changes: len0 changed and req0 dropped during RUN -> counting continues from original len0, done0 still pulses.
